// File: rtl/host_mux_pkg.sv
// Shared types and helpers for the host SPI mux/arbiter slice.
package host_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Ceiling log2, minimum 1 so a 2-host build still gets a 1-bit index.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/host_arb.sv
// Combinational CS#-request arbiter: fixed priority (lowest index) or
// round-robin starting one past the current grant.
module host_arb
  import host_mux_pkg::*;
#(
  parameter int NUM_HOSTS = 4,
  parameter int ARB_MODE  = ARB_FIXED,
  parameter int SEL_W     = clog2(NUM_HOSTS)
) (
  input  logic [NUM_HOSTS-1:0] req,
  input  logic [SEL_W-1:0]     last,
  output logic [SEL_W-1:0]     grant_idx,
  output logic                 grant_vld
);

  logic [SEL_W-1:0] idx;

  // Scan hosts in priority order; first requester found wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_HOSTS; k++) begin
      if (ARB_MODE == ARB_RR) idx = SEL_W'((int'(last) + 1 + k) % NUM_HOSTS);
      else                    idx = SEL_W'(k);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/host_mux_arb.sv
// N-host SPI front-end mux. Routes one host port to the flash-side port and
// reselects only in IDLE, after the selected CS# has been high for a guard
// interval. Contention (another host starting a request while a transaction
// or guard is in progress) is pulsed and counted.
module host_mux_arb
  import host_mux_pkg::*;
#(
  parameter int NUM_HOSTS    = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int ARB_MODE     = ARB_FIXED,
  parameter int CNT_W        = 8,
  localparam int SEL_W       = clog2(NUM_HOSTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HOSTS-1:0] hs_clk,
  input  logic [NUM_HOSTS-1:0] hs_cs_n,
  input  logic [NUM_HOSTS-1:0] hs_mosi,
  output logic [NUM_HOSTS-1:0] hs_miso,
  output logic                 h_clk,
  output logic                 h_cs_n,
  output logic                 h_mosi,
  input  logic                 h_miso,
  input  logic                 sw_override,
  input  logic [SEL_W-1:0]     sw_select,
  output logic [SEL_W-1:0]     sel_idx,
  output logic                 active_transaction,
  output logic                 switching_blocked,
  output logic                 contention,
  output logic [CNT_W-1:0]     contention_cnt
);

  localparam int GW = 8;

  logic [SYNC_STAGES-1:0][NUM_HOSTS-1:0] cs_pipe;
  logic [NUM_HOSTS-1:0] cs_sync, cs_sync_d, fall, sel_oh;
  state_t               state, state_nxt;
  logic [SEL_W-1:0]     sel, sel_nxt, tgt, arb_idx;
  logic [GW-1:0]        gcnt, gcnt_nxt;
  logic                 tgt_vld, arb_vld, sw_in_range, blk_nxt, cont_ev;

  assign cs_sync = cs_pipe[SYNC_STAGES-1];

  // Raw pins go straight through, steered by the registered grant.
  assign h_clk  = hs_clk[sel];
  assign h_cs_n = hs_cs_n[sel];
  assign h_mosi = hs_mosi[sel];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HOSTS; gi++) begin : g_miso
      assign hs_miso[gi] = (sel == SEL_W'(gi)) ? h_miso : 1'b1;
    end
    // Power-of-two host counts cannot express an out-of-range select.
    if ((1 << SEL_W) == NUM_HOSTS) begin : g_rng_full
      assign sw_in_range = 1'b1;
    end else begin : g_rng_part
      assign sw_in_range = (sw_select < SEL_W'(NUM_HOSTS));
    end
  endgenerate

  host_arb #(.NUM_HOSTS(NUM_HOSTS), .ARB_MODE(ARB_MODE), .SEL_W(SEL_W)) u_arb (
    .req       (~cs_sync),
    .last      (sel),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Candidate for the next grant: software choice or arbiter winner.
  always_comb begin
    if (sw_override) begin
      tgt     = sw_select;
      tgt_vld = sw_in_range;
    end else begin
      tgt     = arb_idx;
      tgt_vld = arb_vld;
    end
  end

  // Selection FSM: a live transaction on the current grant beats reselection.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    gcnt_nxt  = gcnt;
    case (state)
      IDLE: begin
        if (!cs_sync[sel])                state_nxt = BUSY;
        else if (tgt_vld && (tgt != sel)) sel_nxt   = tgt;
      end
      BUSY: begin
        if (cs_sync[sel]) begin
          state_nxt = GUARD;
          gcnt_nxt  = '0;
        end
      end
      GUARD: begin
        if (!cs_sync[sel])                         state_nxt = BUSY;
        else if (gcnt == GW'(GUARD_CYCLES - 1))    state_nxt = IDLE;
        else                                       gcnt_nxt  = gcnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Evaluated against the next state so the flag lines up with state.
    blk_nxt = (state_nxt != IDLE) && tgt_vld && (tgt != sel_nxt);
  end

  // Contention: a fresh CS# fall on any non-granted host outside IDLE.
  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
    fall        = cs_sync_d & ~cs_sync;
    cont_ev     = (state != IDLE) && |(fall & ~sel_oh);
  end

  // CS# synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_pipe   <= '1;
      cs_sync_d <= '1;
    end else begin
      cs_pipe[0] <= hs_cs_n;
      for (int s = 1; s < SYNC_STAGES; s++) cs_pipe[s] <= cs_pipe[s-1];
      cs_sync_d  <= cs_sync;
    end
  end

  // Control state, flags and saturating contention counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      sel               <= '0;
      gcnt              <= '0;
      switching_blocked <= 1'b0;
      contention        <= 1'b0;
      contention_cnt    <= '0;
    end else begin
      state             <= state_nxt;
      sel               <= sel_nxt;
      gcnt              <= gcnt_nxt;
      switching_blocked <= blk_nxt;
      contention        <= cont_ev;
      if (cont_ev && (contention_cnt != {CNT_W{1'b1}}))
        contention_cnt <= contention_cnt + 1'b1;
    end
  end

  assign sel_idx            = sel;
  assign active_transaction = |(~cs_sync);

endmodule

// File: tb/tb_host_mux_arb.sv
// Directed bench for host_mux_arb: a fixed-priority 4-host instance carries
// most scenarios; a 5-host round-robin instance covers RR order and
// out-of-range software selects. Grant changes and contention pulses are
// scoreboarded against queues filled by the stimulus process.
module tb_host_mux_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hs_clk, hs_cs_n, hs_mosi, hs_miso;
  logic       h_clk, h_cs_n, h_mosi, h_miso;
  logic       sw_override;
  logic [1:0] sw_select, sel_idx;
  logic       active_transaction, switching_blocked, contention;
  logic [7:0] contention_cnt;

  logic [4:0] r_hs_clk, r_cs_n, r_mosi, r_miso;
  logic       r_h_clk, r_h_cs_n, r_h_mosi, r_ovr, r_act, r_blk, r_cont;
  logic [2:0] r_sel, r_sel_idx;
  logic [7:0] r_cnt;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_sel[$];
  logic [7:0] exp_cnt[$];

  always #5 clk = ~clk;

  host_mux_arb #(.NUM_HOSTS(4), .SYNC_STAGES(2), .GUARD_CYCLES(4), .ARB_MODE(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .hs_clk(hs_clk), .hs_cs_n(hs_cs_n), .hs_mosi(hs_mosi),
    .hs_miso(hs_miso), .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi), .h_miso(h_miso),
    .sw_override(sw_override), .sw_select(sw_select), .sel_idx(sel_idx),
    .active_transaction(active_transaction), .switching_blocked(switching_blocked),
    .contention(contention), .contention_cnt(contention_cnt)
  );

  host_mux_arb #(.NUM_HOSTS(5), .SYNC_STAGES(2), .GUARD_CYCLES(4), .ARB_MODE(1), .CNT_W(8)) dut_rr (
    .clk(clk), .rst(rst), .hs_clk(r_hs_clk), .hs_cs_n(r_cs_n), .hs_mosi(r_mosi),
    .hs_miso(r_miso), .h_clk(r_h_clk), .h_cs_n(r_h_cs_n), .h_mosi(r_h_mosi), .h_miso(h_miso),
    .sw_override(r_ovr), .sw_select(r_sel), .sel_idx(r_sel_idx),
    .active_transaction(r_act), .switching_blocked(r_blk),
    .contention(r_cont), .contention_cnt(r_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever the grant moves or contention pulses.
  initial begin
    logic [1:0] sel_prev;
    logic [1:0] es;
    logic [7:0] ec;
    sel_prev = 2'd0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (sel_idx !== sel_prev) begin
          if (exp_sel.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_sel unexpected grant change got=%0h", sel_idx);
          end else begin
            es = exp_sel.pop_front();
            chk("sb_sel", sel_idx, es);
          end
          sel_prev = sel_idx;
        end
        if (contention === 1'b1) begin
          if (exp_cnt.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_cont unexpected pulse cnt=%0d", contention_cnt);
          end else begin
            ec = exp_cnt.pop_front();
            chk("sb_cont_cnt", contention_cnt, ec);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    hs_cs_n = 4'b1011; hs_clk = 4'b0101; hs_mosi = 4'b0011; h_miso = 1'b0;
    sw_override = 1'b1; sw_select = 2'd0;
    r_cs_n = 5'b11111; r_hs_clk = '0; r_mosi = '0; r_ovr = 1'b1; r_sel = 3'd0;

    // Reset with host 2 mid-transaction
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", sel_idx, 0);
    chk("rst_h_cs_n", h_cs_n, 1);
    chk("rst_h_clk", h_clk, 1);
    chk("rst_h_mosi", h_mosi, 1);
    chk("rst_hs_miso", hs_miso, 4'b1110);
    chk("rst_active", active_transaction, 0);
    chk("rst_blk", switching_blocked, 0);
    chk("rst_cont", contention, 0);
    chk("rst_cnt", contention_cnt, 0);
    chk("rst_rr_sel", r_sel_idx, 0);
    h_miso = 1'b1; #1;
    chk("rst_hs_miso_hi", hs_miso, 4'b1111);
    hs_cs_n = 4'b1111;
    step(1); rst = 1'b0;
    step(3);

    // Override: ask for host 1 while host 0 is busy
    hs_cs_n[0] = 1'b0;
    step(5);
    @(negedge clk);
    chk("ovr_active", active_transaction, 1);
    chk("ovr_busy_sel", sel_idx, 0);
    chk("ovr_busy_blk0", switching_blocked, 0);
    step(1); sw_select = 2'd1; exp_sel.push_back(2'd1);
    step(2);
    @(negedge clk);
    chk("ovr_busy_blk1", switching_blocked, 1);
    chk("ovr_busy_hold", sel_idx, 0);

    // Guard re-entry: CS# back low two cycles after rising
    step(1); hs_cs_n[0] = 1'b1;
    step(2); hs_cs_n[0] = 1'b0;
    for (int i = 3; i <= 9; i++) begin
      @(posedge clk); @(negedge clk);
      chk("reentry_blk", switching_blocked, 1);
      chk("reentry_sel", sel_idx, 0);
    end

    // Final release: four guard cycles, IDLE, then switch
    step(1); hs_cs_n[0] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("guard_last_blk", switching_blocked, 1);
    chk("guard_last_sel", sel_idx, 0);
    @(posedge clk); @(negedge clk);
    chk("idle_blk", switching_blocked, 0);
    chk("idle_sel", sel_idx, 0);
    @(posedge clk); @(negedge clk);
    chk("switch_sel", sel_idx, 1);
    h_miso = 1'b0; #1;
    chk("sel1_hs_miso", hs_miso, 4'b1101);
    chk("sel1_h_clk", h_clk, 0);
    chk("sel1_h_mosi", h_mosi, 1);

    // Back to host 0, then auto fixed priority with hosts 1 and 3
    step(1); sw_select = 2'd0; exp_sel.push_back(2'd0);
    step(3);
    sw_override = 1'b0;
    step(3);
    hs_cs_n = 4'b0101; exp_sel.push_back(2'd1);
    repeat (2) @(posedge clk); @(negedge clk);
    chk("fp_early", sel_idx, 0);
    @(posedge clk); @(negedge clk);
    chk("fp_grant", sel_idx, 1);
    @(posedge clk); @(negedge clk);
    chk("fp_active", active_transaction, 1);
    chk("fp_blk", switching_blocked, 0);
    chk("fp_cont", contention, 0);
    step(1); hs_cs_n = 4'b1111;
    step(10);

    // Contention: host 0 busy, hosts 1 and 2 fall alternately 300 times
    hs_cs_n[0] = 1'b0; exp_sel.push_back(2'd0);
    step(5);
    for (int k = 1; k <= 300; k++) begin
      int h;
      h = (k % 2) ? 1 : 2;
      exp_cnt.push_back((k > 255) ? 8'd255 : 8'(k));
      hs_cs_n[h] = 1'b0;
      step(2);
      hs_cs_n[h] = 1'b1;
      step(2);
    end
    exp_cnt.push_back(8'd255);
    hs_cs_n[2:1] = 2'b00;
    step(3);
    hs_cs_n[2:1] = 2'b11;
    step(4);
    @(negedge clk);
    chk("cnt_saturated", contention_cnt, 255);
    step(1); hs_cs_n[0] = 1'b1;
    step(10);

    // Round-robin instance: out-of-range select ignored, then RR order
    r_sel = 3'd2;
    step(3); @(negedge clk);
    chk("rr_ovr_sel2", r_sel_idx, 2);
    step(1); r_sel = 3'd5;
    step(4); @(negedge clk);
    chk("rr_oor_sel", r_sel_idx, 2);
    chk("rr_oor_blk", r_blk, 0);
    step(1); r_cs_n = 5'b10110; r_ovr = 1'b0;
    repeat (2) @(posedge clk); @(negedge clk);
    chk("rr_early", r_sel_idx, 2);
    @(posedge clk); @(negedge clk);
    chk("rr_first", r_sel_idx, 3);
    repeat (2) @(posedge clk); @(negedge clk);
    chk("rr_busy_blk", r_blk, 1);
    chk("rr_busy_act", r_act, 1);
    step(1); r_cs_n[3] = 1'b1;
    step(12); @(negedge clk);
    chk("rr_second", r_sel_idx, 0);
    step(1); r_cs_n = 5'b11111;
    step(5);

    @(negedge clk);
    chk("sb_sel_drained", exp_sel.size(), 0);
    chk("sb_cnt_drained", exp_cnt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
